// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch (IF) and load/store (LS).
// Ports: clk/reset, IF and LS req/gnt/valid/rdata handshakes, memory side.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int MAX_STARVE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW =
    (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              own_ls_q, own_ls_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic              ls_valid_q, ls_valid_d;
  logic              last;
  logic              starved;
  logic              ls_win;
  logic              if_win;

  assign last    = (state_q == BUSY)
                && (cnt_q == CW'(LAT - 1));
  assign starved = (starve_q == SW'(MAX_STARVE));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    own_ls_d   = own_ls_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    if_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    ls_win     = 1'b0;
    if_win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // LS has priority until IF has lost MAX_STARVE times
        ls_win = ls_req && !(if_req && starved);
        if_win = if_req && !ls_win;
        unique case (1'b1)
          ls_win: begin
            own_ls_d = 1'b1;
            addr_d   = {ls_addr[ADDR_W-1:2], 2'b00};
            we_d     = ls_we;
            wdata_d  = ls_wdata;
            ls_gnt_d = 1'b1;
            state_d  = BUSY;
            cnt_d    = '0;
            if (if_req && !starved)
              starve_d = starve_q + SW'(1);
          end
          if_win: begin
            own_ls_d = 1'b0;
            addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
            we_d     = 1'b0;
            if_gnt_d = 1'b1;
            state_d  = BUSY;
            cnt_d    = '0;
            starve_d = '0;
          end
          default: ;
        endcase
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (own_ls_q) begin
            ls_valid_d = 1'b1;
            if (!we_q)
              ls_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      own_ls_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      own_ls_q   <= own_ls_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_gnt_q   <= if_gnt_d;
      ls_gnt_q   <= ls_gnt_d;
      if_valid_q <= if_valid_d;
      ls_valid_q <= ls_valid_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_valid  = if_valid_q;
  assign ls_valid  = ls_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  // the write strobe exists only in the last busy cycle
  assign mem_we    = last && we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: schedule-based model, directed and
// random IF/LS traffic against a bench-side word memory.
module tb_mem_port_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int MS  = 3;
  localparam int NW  = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          if_gnt, if_valid, ls_gnt, ls_valid;
  logic [DW-1:0] if_rdata, ls_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .LAT(LAT), .MAX_STARVE(MS)
  ) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid),
    .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // environment memory, pattern A5000000 + word index
  logic [DW-1:0] mem [NW];
  bit mem_ready;
  assign mem_rdata = mem[mem_addr[AW-1:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < NW; i++)
        mem[i] <= 32'hA500_0000 + DW'(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[AW-1:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    else
      pass_cnt++;
  endtask

  // model: transaction schedule by absolute cycle number
  logic [DW-1:0] shadow [NW];
  bit            sh_init;
  int            cyc = 0;
  int            arb_cyc = 0;
  int            gnt_cyc = -1;
  int            we_cyc = -1;
  int            val_cyc = -1;
  int            m_starve = 0;
  bit            m_own_ls, m_we, ls_wins;
  logic [AW-1:0] m_addr, e_maddr;
  logic [DW-1:0] m_wdata, m_cap;
  logic [DW-1:0] e_if_rd, e_ls_rd;

  always @(negedge clk) begin
    if (!sh_init) begin
      for (int i = 0; i < NW; i++)
        shadow[i] = 32'hA500_0000 + DW'(i);
      sh_init = 1'b1;
    end
    cyc++;
    if (!rst_n) begin
      chk("rst_if_gnt", DW'(if_gnt), 0);
      chk("rst_ls_gnt", DW'(ls_gnt), 0);
      chk("rst_if_val", DW'(if_valid), 0);
      chk("rst_ls_val", DW'(ls_valid), 0);
      chk("rst_if_rd", if_rdata, 0);
      chk("rst_ls_rd", ls_rdata, 0);
      chk("rst_maddr", DW'(mem_addr), 0);
      chk("rst_mwe", DW'(mem_we), 0);
      chk("rst_mwd", mem_wdata, 0);
      arb_cyc  = cyc + 1;
      gnt_cyc  = -1;
      we_cyc   = -1;
      val_cyc  = -1;
      m_starve = 0;
      e_if_rd  = '0;
      e_ls_rd  = '0;
      e_maddr  = '0;
    end else begin
      if (cyc == val_cyc) begin
        if (m_own_ls) begin
          if (!m_we) e_ls_rd = m_cap;
        end else begin
          e_if_rd = m_cap;
        end
      end
      chk("if_gnt", DW'(if_gnt),
          DW'(cyc == gnt_cyc && !m_own_ls));
      chk("ls_gnt", DW'(ls_gnt),
          DW'(cyc == gnt_cyc && m_own_ls));
      chk("if_valid", DW'(if_valid),
          DW'(cyc == val_cyc && !m_own_ls));
      chk("ls_valid", DW'(ls_valid),
          DW'(cyc == val_cyc && m_own_ls));
      chk("if_rdata", if_rdata, e_if_rd);
      chk("ls_rdata", ls_rdata, e_ls_rd);
      chk("mem_addr", DW'(mem_addr), DW'(e_maddr));
      chk("mem_we", DW'(mem_we),
          DW'(cyc == we_cyc && m_we));
      if (cyc == we_cyc && m_we)
        chk("mem_wdata", mem_wdata, m_wdata);
      if (cyc == we_cyc) begin
        m_cap = shadow[m_addr[AW-1:2]];
        if (m_we) shadow[m_addr[AW-1:2]] = m_wdata;
      end
      if (cyc == arb_cyc) begin
        if (ls_req || if_req) begin
          ls_wins = ls_req &&
                    !(if_req && m_starve >= MS);
          if (ls_wins) begin
            m_own_ls = 1'b1;
            m_we     = ls_we;
            m_addr   = ls_addr & ~AW'(3);
            m_wdata  = ls_wdata;
            if (if_req && m_starve < MS)
              m_starve++;
          end else begin
            m_own_ls = 1'b0;
            m_we     = 1'b0;
            m_addr   = if_addr & ~AW'(3);
            m_starve = 0;
          end
          e_maddr = m_addr;
          gnt_cyc = cyc + 1;
          we_cyc  = cyc + LAT;
          val_cyc = cyc + LAT + 1;
          arb_cyc = cyc + LAT + 1;
        end else begin
          arb_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int      n, ng, nv;
  int      gc, vc;
  logic [7:0] seq;
  int      nbad;

  initial begin
    rst_n    = 1'b0;
    if_req   = 1'b1;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    repeat (3) tick();
    chk("hold_rst_gnt", DW'(if_gnt), 0);

    // fetch after reset release
    rst_n = 1'b1;
    tick();
    chk("rel_if_gnt", DW'(if_gnt), 1);
    if_req = 1'b0;
    tick();
    tick();
    chk("rel_if_val", DW'(if_valid), 1);
    chk("rel_if_rd", if_rdata, 32'hA500_0000);

    // load, unaligned address
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 10'h013;
    tick();
    chk("ld_gnt", DW'(ls_gnt), 1);
    chk("ld_maddr1", DW'(mem_addr), 32'h010);
    ls_req = 1'b0;
    tick();
    chk("ld_maddr2", DW'(mem_addr), 32'h010);
    chk("ld_we", DW'(mem_we), 0);
    tick();
    chk("ld_val", DW'(ls_valid), 1);
    chk("ld_rd", ls_rdata, 32'hA500_0004);

    // store
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 10'h020;
    ls_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_gnt", DW'(ls_gnt), 1);
    chk("st_we1", DW'(mem_we), 0);
    ls_req = 1'b0;
    tick();
    chk("st_we2", DW'(mem_we), 1);
    chk("st_maddr", DW'(mem_addr), 32'h020);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_val", DW'(ls_valid), 1);
    chk("st_we3", DW'(mem_we), 0);
    chk("st_rd", ls_rdata, 32'hA500_0004);
    chk("st_mem", mem[8], 32'hDEAD_BEEF);

    // contention: both held high
    ls_we   = 1'b0;
    ls_addr = 10'h004;
    if_addr = 10'h00C;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    n   = 0;
    seq = '0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      tick();
      if (if_gnt || ls_gnt) begin
        seq = {seq[6:0], ls_gnt};
        n++;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("cont_n", DW'(n), 8);
    chk("cont_seq", DW'(seq), 32'hEE);
    repeat (LAT + 1) tick();

    // back-to-back fetches
    if_req  = 1'b1;
    if_addr = '0;
    ng = 0; nv = 0; gc = 0; vc = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (if_gnt) begin
        gc = gc * 16 + k;
        ng++;
        if (ng == 3) if_req = 1'b0;
        else if_addr = if_addr + AW'(4);
      end
      if (if_valid) begin
        vc = vc * 16 + k;
        chk("b2b_rd", if_rdata,
            32'hA500_0000 + DW'(nv));
        nv++;
      end
    end
    if_req = 1'b0;
    chk("b2b_gnt_cyc", DW'(gc), 32'h147);
    chk("b2b_val_cyc", DW'(vc), 32'h369);

    // reset during the first busy cycle of a store
    tick();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 10'h040;
    ls_wdata = 32'h1234_5678;
    tick();
    chk("mr_gnt", DW'(ls_gnt), 1);
    rst_n  = 1'b0;
    ls_req = 1'b0;
    repeat (3) begin
      tick();
      chk("mr_we", DW'(mem_we), 0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("mr_val", DW'(ls_valid), 0);
      chk("mr_we2", DW'(mem_we), 0);
    end
    chk("mr_mem", mem[16], 32'hA500_0010);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (!if_req || if_gnt) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom);
      end
      if (!ls_req || ls_gnt) begin
        ls_req   = ($urandom_range(0, 2) != 0);
        ls_we    = $urandom_range(0, 1) == 1;
        ls_addr  = AW'($urandom);
        ls_wdata = $urandom;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (2 * LAT + 4) tick();

    nbad = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== shadow[i]) nbad++;
    chk("mem_final", DW'(nbad), 0);

    $display("%0d/%0d checks passed",
             pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable instruction/data memory between two requesters: the instruction fetch stage (IF) and the load/store stage (LS).
- Serialises accesses and drives the memory's address, write-enable and write-data inputs.
- Returns 32-bit read data to the winning requester.
- Fetch and LS stall logic is derived from its grant/valid handshake.

Parameters:
- ADDR_W, 10, byte address width of the memory.
- DATA_W, 32, word width.
- LAT, 2, memory access cycles per transaction, must be >= 1.
- MAX_STARVE, 3, consecutive IF losses before IF is forced to win.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_gnt.
- if_addr  input  ADDR_W  fetch byte address; bits [1:0] are forced to 0.
- if_gnt  output  1  one-cycle pulse: IF request accepted.
- if_valid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_W  fetched word; held until the next if_valid.
- ls_req  input  1  load/store request; held high until ls_gnt.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  data byte address; bits [1:0] are forced to 0.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  one-cycle pulse: LS request accepted.
- ls_valid  output  1  one-cycle pulse: load data valid or store completed.
- ls_rdata  output  DATA_W  loaded word; held until the next ls_valid. Unchanged on a store.
- mem_addr  output  ADDR_W  address to memory.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  DATA_W  data to memory.
- mem_rdata  input  DATA_W  word read from memory at mem_addr, combinational.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; cnt=0; starve=0; owner=IF.
  - All outputs 0, including rdata registers and mem_addr.
  - Any transaction in flight is dropped; no mem_we pulse may occur. Requests must be re-issued after reset.
- States: IDLE, BUSY.
- IDLE arbitration, evaluated every IDLE cycle:
  - Only ls_req: LS wins.
  - Only if_req: IF wins.
  - Both: LS wins unless starve == MAX_STARVE, in which case IF wins.
  - On a win: latch owner, address, we and wdata; go to BUSY with cnt=0. The owner's gnt pulses high in the first BUSY cycle.
  - No request: stay in IDLE; mem_we=0; mem_addr holds its last value.
- starve counter:
  - +1 on each IDLE arbitration where if_req=1 and LS wins, saturating at MAX_STARVE.
  - Cleared to 0 when IF wins.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched values, stable for all LAT cycles.
  - cnt increments each cycle.
  - In the final cycle (cnt == LAT-1):
    - mem_we = latched we. This is the only cycle mem_we can be 1, so each store gives exactly one pulse.
    - mem_rdata is captured into the owner's rdata register (loads and fetches).
    - Next state is IDLE.
- Completion: the owner's valid pulses for one cycle in the first IDLE cycle after BUSY. Arbitration runs in that same cycle, so back-to-back transactions are allowed.
- Timing: req first seen in IDLE at cycle 0 → gnt at cycle 1 → valid at cycle LAT+1. Next gnt earliest at cycle LAT+2. Peak throughput is 1 transaction per LAT+1 cycles.
- Requests that change or drop while BUSY are ignored until IDLE. A requester that drops req before gnt is simply not served.
- Mutual exclusion: if_gnt and ls_gnt are never both high; if_valid and ls_valid are never both high.
- Address arithmetic: addr[1:0] are zeroed, with no error flag. There is no wrap check; the address is passed through mod 2^ADDR_W.

Test Plan:
- Reset behaviour: hold reset=0 with if_req=1 → all outputs 0. Release at cycle 0 → if_gnt at cycle 1, if_valid at cycle 3 (LAT=2), if_rdata = mem word at if_addr=0x000.
- Load: ls_req=1, ls_we=0, ls_addr=0x013 → mem_addr=0x010 for 2 cycles. ls_rdata = word at 0x010 with ls_valid pulsing once; mem_we never high.
- Store: ls_we=1, ls_addr=0x020, ls_wdata=0xDEADBEEF → exactly one mem_we pulse in the second BUSY cycle with mem_addr=0x020 and mem_wdata=0xDEADBEEF. ls_valid follows one cycle later; ls_rdata unchanged.
- Contention and starvation: if_req and ls_req both held high continuously (LS re-requests after each valid) → grant order LS, LS, LS, IF, LS, LS, LS, IF... (MAX_STARVE=3). starve returns to 0 after each IF grant.
- Mid-operation reset: assert reset in the first BUSY cycle of a store → mem_we stays 0 throughout, no valid pulse, state returns to IDLE.
- Back-to-back: continuous if_req with if_addr stepping 0,4,8 → if_gnt at cycles 1, 4, 7 and if_valid at cycles 3, 6, 9, with matching words.
